// File: rtl/prog_clk_div_if.sv
// prog_clk_div_if -- configuration request channel for prog_clk_div.
//   cfg_valid : request valid (master -> slave)
//   cfg_ready : request accepted on posedge when valid & ready (slave -> master)
//   cfg_ch    : target channel index
//   cfg_div   : period in clk cycles (raw, clamped by the slave)
//   cfg_high  : high time in clk cycles, 0 selects 50% (raw, clamped by the slave)
interface prog_clk_div_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_high;

   modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready);
endinterface

// File: rtl/prog_clk_div.sv
// prog_clk_div -- multi-channel programmable clock divider.
// Each channel produces a registered, duty-configurable divided clock from clk.
// New divide/high settings land in a per-channel shadow register and are
// copied to the active set at a period boundary (or immediately when idle),
// so output waveforms never glitch.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   cfg      : prog_clk_div_if.slave config request channel
//   ch_en    : per-channel run request
//   clk_out  : per-channel divided clock (flop output)
//   running  : per-channel, channel is in RUN or STOPPING
//   tick     : per-channel 1-cycle pulse at each period start
// Optional: define PROG_CLK_DIV_TICK_EN to build the tick logic; otherwise
// tick is tied to 0.

module prog_clk_div_ch #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             acc,      // accepted request for this channel
   input  logic [CNT_W-1:0] div_in,   // already clamped
   input  logic [CNT_W-1:0] high_in,  // already clamped
   output logic             pending,
   output logic             clk_out,
   output logic             running,
   output logic             tick
);
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_adv;
   logic [CNT_W-1:0] div_a, high_a, div_s, high_s;
   logic [CNT_W-1:0] high_use;
   logic             pend, last, xfer, clk_q, clk_n;

   always_comb begin
      last     = (cnt == div_a - 1'b1);
      // idle channels take the shadow at once; running ones only at wrap
      xfer     = pend && ((state == IDLE) || last);
      high_use = xfer ? high_s : high_a;
      cnt_adv  = last ? '0 : cnt + 1'b1;
      state_n  = state;
      cnt_n    = cnt;
      clk_n    = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_n = RUN;
               cnt_n   = '0;
            end
         end
         RUN: begin
            cnt_n = cnt_adv;
            if (!en) state_n = STOPPING;
         end
         STOPPING: begin
            if (en) begin
               state_n = RUN;
               cnt_n   = cnt_adv;
            end else if (last) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n   = cnt_adv;
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n != IDLE) clk_n = (cnt_n < high_use);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         clk_q  <= 1'b0;
         div_a  <= CNT_W'(2);
         high_a <= CNT_W'(1);
         div_s  <= CNT_W'(2);
         high_s <= CNT_W'(1);
         pend   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         clk_q <= clk_n;
         if (xfer) begin
            div_a  <= div_s;
            high_a <= high_s;
         end
         if (acc) begin
            div_s  <= div_in;
            high_s <= high_in;
         end
         // acc only fires while pend is clear, so it never races xfer
         pend <= acc | (pend & ~xfer);
      end
   end

`ifdef PROG_CLK_DIV_TICK_EN
   logic tick_q;
   always_ff @(posedge clk) begin
      if (rst) tick_q <= 1'b0;
      else     tick_q <= (state_n != IDLE) && (cnt_n == '0);
   end
   assign tick = tick_q;
`else
   assign tick = 1'b0;
`endif

   assign pending = pend;
   assign clk_out = clk_q;
   assign running = (state != IDLE);
endmodule

module prog_clk_div #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   prog_clk_div_if.slave     cfg,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] running,
   output logic [NUM_CH-1:0] tick
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CNT_W-1:0]  div_eff, high_eff;
   logic [NUM_CH-1:0] pending, acc;
   logic              ch_ok;

   // clamp once at the port; channels only ever see legal values
   always_comb begin
      div_eff = (cfg.cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_div;
      if (cfg.cfg_high == '0) begin
         high_eff = div_eff >> 1;
      end else begin
         high_eff = (cfg.cfg_high > div_eff - 1'b1) ? div_eff - 1'b1 : cfg.cfg_high;
         if (high_eff == '0) high_eff = CNT_W'(1);
      end
   end

   // out-of-range channels are accepted and dropped
   assign ch_ok         = (int'(cfg.cfg_ch) < NUM_CH);
   assign cfg.cfg_ready = ch_ok ? ~pending[cfg.cfg_ch] : 1'b1;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign acc[i] = cfg.cfg_valid && cfg.cfg_ready && ch_ok &&
                      (cfg.cfg_ch == CH_W'(i));
      prog_clk_div_ch #(.CNT_W(CNT_W)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (ch_en[i]),
         .acc     (acc[i]),
         .div_in  (div_eff),
         .high_in (high_eff),
         .pending (pending[i]),
         .clk_out (clk_out[i]),
         .running (running[i]),
         .tick    (tick[i])
      );
   end
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div -- directed + randomized bench for prog_clk_div.
// A period-level reference model (position within period, active/shadow
// settings, stop request) predicts clk_out/running/tick/cfg_ready each cycle.
module tb_prog_clk_div;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] clk_out, running, tick;

   prog_clk_div_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

   prog_clk_div #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .cfg     (cfg_if),
      .ch_en   (ch_en),
      .clk_out (clk_out),
      .running (running),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit m_run  [NUM_CH];
   bit m_stop [NUM_CH];
   bit m_pend [NUM_CH];
   int m_pos  [NUM_CH];
   int m_div  [NUM_CH];
   int m_high [NUM_CH];
   int m_sdiv [NUM_CH];
   int m_shigh[NUM_CH];

   function automatic void clamp(input int d, input int h, output int dd, output int hh);
      dd = (d < 2) ? 2 : d;
      if (h == 0) hh = dd / 2;
      else begin
         hh = (h > dd - 1) ? dd - 1 : h;
         if (hh < 1) hh = 1;
      end
   endfunction

   task automatic model_update();
      int  dd, hh;
      bit  acc, last;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            m_run[i] = 0; m_stop[i] = 0; m_pend[i] = 0; m_pos[i] = 0;
            m_div[i] = 2; m_high[i] = 1; m_sdiv[i] = 2; m_shigh[i] = 1;
         end else begin
            acc = cfg_if.cfg_valid && (int'(cfg_if.cfg_ch) == i) && !m_pend[i];
            if (!m_run[i]) begin
               if (m_pend[i]) begin
                  m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
               end
               if (ch_en[i]) begin
                  m_run[i] = 1; m_stop[i] = 0; m_pos[i] = 0;
               end
            end else begin
               last = (m_pos[i] == m_div[i] - 1);
               if (last && m_pend[i]) begin
                  m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
               end
               if (m_stop[i] && !ch_en[i] && last) begin
                  m_run[i] = 0; m_pos[i] = 0;
               end else begin
                  m_pos[i]  = last ? 0 : m_pos[i] + 1;
                  m_stop[i] = !ch_en[i];
               end
            end
            if (acc) begin
               clamp(int'(cfg_if.cfg_div), int'(cfg_if.cfg_high), dd, hh);
               m_sdiv[i] = dd; m_shigh[i] = hh; m_pend[i] = 1;
            end
         end
      end
   endtask

   task automatic check_model();
      logic [NUM_CH-1:0] e_clk, e_run, e_tick;
      logic              e_rdy;
      for (int i = 0; i < NUM_CH; i++) begin
         e_clk[i] = m_run[i] && (m_pos[i] < m_high[i]);
         e_run[i] = m_run[i];
`ifdef PROG_CLK_DIV_TICK_EN
         e_tick[i] = m_run[i] && (m_pos[i] == 0);
`else
         e_tick[i] = 1'b0;
`endif
      end
      e_rdy = (int'(cfg_if.cfg_ch) >= NUM_CH) || !m_pend[cfg_if.cfg_ch];
      checks++;
      assert (clk_out === e_clk) else begin
         failures++; $error("FAIL model_clk_out got=%b exp=%b t=%0t", clk_out, e_clk, $time);
      end
      checks++;
      assert (running === e_run) else begin
         failures++; $error("FAIL model_running got=%b exp=%b t=%0t", running, e_run, $time);
      end
      checks++;
      assert (tick === e_tick) else begin
         failures++; $error("FAIL model_tick got=%b exp=%b t=%0t", tick, e_tick, $time);
      end
      checks++;
      assert (cfg_if.cfg_ready === e_rdy) else begin
         failures++; $error("FAIL model_ready got=%b exp=%b t=%0t", cfg_if.cfg_ready, e_rdy, $time);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++; $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_model();
   endtask

   task automatic cfg_write(input int ch, input int d, input int h);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = ch[0:0];
      cfg_if.cfg_div   = d[CNT_W-1:0];
      cfg_if.cfg_high  = h[CNT_W-1:0];
      step();
      cfg_if.cfg_valid = 1'b0;
   endtask

   // bounded wait for the model to report all channels idle
   task automatic wait_idle();
      int n = 0;
      while ((m_run[0] || m_run[1]) && n < 40) begin
         step();
         n++;
      end
      chk("wait_idle_bound", running, '0);
   endtask

   initial begin
      rst = 1'b1; ch_en = '0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0;
      cfg_if.cfg_div = '0; cfg_if.cfg_high = '0;
      step(); step();
      chk("rst_clk_out", clk_out, 0);
      chk("rst_running", running, 0);
      chk("rst_ready", cfg_if.cfg_ready, 1);

      // default config: clk/2 on ch0, ch1 quiet
      rst = 1'b0; ch_en = 2'b01;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("div2_clk0", clk_out[0], (k % 2 == 0));
         chk("div2_ch1", {running[1], clk_out[1]}, 0);
      end
      ch_en = '0; wait_idle();

      // div=5, 50% -> 2 high / 3 low
      cfg_write(0, 5, 0); step();
      ch_en = 2'b01;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("div5_clk0", clk_out[0], ((k % 5) < 2));
`ifdef PROG_CLK_DIV_TICK_EN
         chk("div5_tick0", tick[0], ((k % 5) == 0));
`endif
      end
      ch_en = '0; wait_idle();

      // mid-period reconfig: 4/2 -> 8/6 at the period boundary
      cfg_write(0, 4, 2); step();
      ch_en = 2'b01; step(); step();
      cfg_write(0, 8, 6);
      chk("reconf_ready_blk0", cfg_if.cfg_ready, 0);
      step();
      chk("reconf_old_period", clk_out[0], 0);
      chk("reconf_ready_blk1", cfg_if.cfg_ready, 0);
      step();
      chk("reconf_ready_back", cfg_if.cfg_ready, 1);
      chk("reconf_new_start", clk_out[0], 1);
      for (int k = 1; k < 8; k++) begin
         step();
         chk("reconf_6h2l", clk_out[0], (k < 6));
      end
      ch_en = '0; wait_idle();

      // clamp: div=0 high=0 behaves as 2/1
      cfg_write(0, 0, 0); step();
      ch_en = 2'b01;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("clamp_div0", clk_out[0], (k % 2 == 0));
      end
      ch_en = '0; wait_idle();

      // clamp: div=6 high=9 -> 5 high / 1 low
      cfg_write(0, 6, 9); step();
      ch_en = 2'b01;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("clamp_high", clk_out[0], ((k % 6) < 5));
      end
      ch_en = '0; wait_idle();

      // stop at cnt=1: finishes the period then idles
      ch_en = 2'b01; step(); step();
      ch_en = 2'b00;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stop_still_running", running[0], 1);
      end
      step();
      chk("stop_idle_run", running[0], 0);
      chk("stop_idle_clk", clk_out[0], 0);

      // re-enable during STOPPING: period continues seamlessly
      ch_en = 2'b01; step(); step();
      ch_en = 2'b00; step();
      ch_en = 2'b01;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("restop_run", running[0], 1);
         chk("restop_clk", clk_out[0], (((k + 3) % 6) < 5));
      end

      // reset in the high phase
      rst = 1'b1; step();
      chk("midrst_clk", clk_out, 0);
      chk("midrst_run", running, 0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("midrst_div2", clk_out[0], (k % 2 == 0));
      end
      ch_en = '0; wait_idle();

      // both channels div=3 enabled together stay aligned
      cfg_write(0, 3, 0); cfg_write(1, 3, 0); step();
      ch_en = 2'b11;
      for (int k = 0; k < 9; k++) begin
         step();
         chk("align_div3", clk_out, ((k % 3) == 0) ? 2'b11 : 2'b00);
      end

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 9) == 0) ch_en[i] = ~ch_en[i];
         cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_if.cfg_ch    = 1'($urandom_range(0, NUM_CH - 1));
         cfg_if.cfg_div   = CNT_W'($urandom_range(0, 9));
         cfg_if.cfg_high  = CNT_W'($urandom_range(0, 11));
         step();
      end
      rst = 1'b0; cfg_if.cfg_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Synthesizable multi-channel programmable clock generator.
- Each channel derives a divided, duty-configurable output from the single system clock.
- Divide ratio and high time are programmable at run time through a valid/ready config port.
- Config changes take effect glitch-free at period boundaries; channels are started and stopped cleanly.
- Sits between the system clock root and slow peripheral/test logic that needs frequency-configurable clock-enables or clocks.

Parameters:
- NUM_CH, 2, number of independent output channels (1..8).
- CNT_W, 16, width of divide and high-time counters/registers.
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, do not override).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config request accepted when valid&ready on posedge.
- cfg_ch  input  CH_W  target channel.
- cfg_div  input  CNT_W  period in clk cycles.
- cfg_high  input  CNT_W  high time in clk cycles; 0 = 50% (floor(div/2)).
- ch_en  input  NUM_CH  per-channel run request.
- clk_out  output  NUM_CH  divided clock, registered.
- running  output  NUM_CH  channel in RUN or STOPPING.
- tick  output  NUM_CH  1-cycle pulse at the start of each period (see Optional Feature).

Behaviour:
- Reset (sync, rst=1 at posedge): clk_out=0, running=0, tick=0, cfg_ready=1, all channels IDLE.
- Reset values: active div=2, active high=1, cnt=0, no pending config.
- Reset mid-operation: outputs go to reset values on the next edge. There is no period completion.
- Clamping, applied at accept time:
  - div_eff = max(cfg_div, 2).
  - high=0 → high_eff = div_eff/2 (floor).
  - Otherwise high_eff = min(cfg_high, div_eff-1), then max(high_eff, 1).
- Config handshake:
  - Each channel has one shadow register plus a pending flag.
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - On accept: shadow <= clamped values, pending <= 1.
  - cfg_ch >= NUM_CH: request is accepted and discarded (ready=1, no effect).
- Shadow-to-active transfer:
  - In IDLE: on the edge after accept.
  - In RUN: on the edge where cnt==div-1 (last cycle of the period), so the new period starts at cnt=0 with the new values.
  - Transfer clears pending.
  - Accept and transfer in the same cycle for the same channel: transfer uses the previous shadow; the new request is blocked because ready=0.
- Per-channel FSM:
  - IDLE: cnt=0, clk_out=0. ch_en=1 → RUN (cnt=0).
  - RUN: cnt increments and wraps at div-1 → 0. clk_out next = (cnt_next < high). ch_en=0 → STOPPING.
  - STOPPING: continues counting; at the cnt==div-1 edge → IDLE with clk_out=0. ch_en=1 again before then → back to RUN with no phase disturbance.
- Latency: ch_en rise at edge N → clk_out=1 from edge N+1. First full period = div cycles.
- Output: clk_out is a flop output (no combinational gating) and produces no glitches.
- Simultaneous enables: channels enabled in the same cycle with equal div stay phase-aligned.

Optional Feature:
- Macro: PROG_CLK_DIV_TICK_EN.
- Defined: tick[i]=1 for exactly one cycle, coincident with clk_out[i] rising at cnt=0 of each RUN/STOPPING period.
- Not defined: tick tied to 0; no tick logic synthesized.

Test Plan:
- Reset, then ch_en=01 with default config → clk_out[0] = 1,0,1,0… (clk/2); running[0]=1; channel 1 stays 0.
- cfg ch0 div=5 high=0 in IDLE, enable → 2 cycles high, 3 low, repeating. With TICK_EN, tick[0] pulses every 5 cycles.
- While running div=4 high=2, cfg div=8 high=6 mid-period:
  - Current period completes unchanged.
  - Next period is 6 high / 2 low.
  - cfg_ready for ch0 = 0 until the transfer edge, then 1.
- Clamp checks:
  - cfg div=0 high=0 → behaves as div=2 high=1.
  - cfg div=6 high=9 → 5 high / 1 low.
- ch_en[0] dropped at cnt=1 of div=6 → runs to cnt=5, then IDLE with clk_out=0 and running=0. Re-enabling during STOPPING keeps the period seamless.
- rst asserted mid-high phase → next edge clk_out=0, running=0, div back to 2. Both channels enabled together with div=3 → identical waveforms.
